// File: rtl/tt_vpu_ovi_issue_queue.sv
// OVI issue queue: buffers issue packets, tracks in-order next_senior/kill dispatch,
// offers senior head entries to execution and returns one issue credit per freed slot.
module tt_vpu_ovi_issue_queue #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [31:0]      issue_inst,
    input  logic [4:0]       issue_sb_id,
    input  logic [63:0]      issue_scalar_opnd,
    input  logic [39:0]      issue_vcsr,
    output logic             issue_credit,
    input  logic [4:0]       dispatch_sb_id,
    input  logic             dispatch_next_senior,
    input  logic             dispatch_kill,
    output logic             exe_valid,
    input  logic             exe_ready,
    output logic [31:0]      exe_inst,
    output logic [4:0]       exe_sb_id,
    output logic [63:0]      exe_scalar_opnd,
    output logic [39:0]      exe_vcsr,
    output logic [PTR_W:0]   occupancy,
    output logic             err_overflow,
    output logic             err_dispatch
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ISSUED = 2'd1;
    localparam logic [1:0] ST_SENIOR = 2'd2;
    localparam logic [1:0] ST_KILLED = 2'd3;

    localparam logic [0:0] FSM_INIT = 1'b0;
    localparam logic [0:0] FSM_RUN  = 1'b1;

    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] INIT_CRED = (PTR_W+1)'(DEPTH);

    logic [1:0]     st_q    [DEPTH];
    logic [31:0]    inst_q  [DEPTH];
    logic [4:0]     sb_q    [DEPTH];
    logic [63:0]    opnd_q  [DEPTH];
    logic [39:0]    vcsr_q  [DEPTH];

    logic [PTR_W:0]   wr_ptr, dp_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_idx, dp_idx, rd_idx;
    logic [PTR_W:0]   init_cnt;
    logic [0:0]       fsm_q;
    logic             credit_q, err_ovf_q, err_dsp_q;

    logic       full, issue_acc, disp_ev, disp_ok, disp_err, pop;
    logic [1:0] head_st;

    always_comb begin
        wr_idx    = wr_ptr[PTR_W-1:0];
        dp_idx    = dp_ptr[PTR_W-1:0];
        rd_idx    = rd_ptr[PTR_W-1:0];
        full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
        issue_acc = issue_valid && !full;
        disp_ev   = dispatch_next_senior || dispatch_kill;
        // Comparing against wr_ptr before this cycle's issue hides same-cycle writes.
        disp_ok   = disp_ev && (dp_ptr != wr_ptr);
        disp_err  = disp_ev && ((dp_ptr == wr_ptr)
                              || (dispatch_next_senior && dispatch_kill)
                              || (dispatch_sb_id != sb_q[dp_idx]));
        head_st   = st_q[rd_idx];
        exe_valid = (head_st == ST_SENIOR);
        pop       = (exe_valid && exe_ready) || (head_st == ST_KILLED);
    end

    always_comb begin
        exe_inst        = exe_valid ? inst_q[rd_idx] : '0;
        exe_sb_id       = exe_valid ? sb_q[rd_idx]   : '0;
        exe_scalar_opnd = exe_valid ? opnd_q[rd_idx] : '0;
        exe_vcsr        = exe_valid ? vcsr_q[rd_idx] : '0;
        occupancy       = wr_ptr - rd_ptr;
        issue_credit    = credit_q;
        err_overflow    = err_ovf_q;
        err_dispatch    = err_dsp_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) st_q[i] <= ST_EMPTY;
            wr_ptr    <= '0;
            dp_ptr    <= '0;
            rd_ptr    <= '0;
            fsm_q     <= FSM_INIT;
            init_cnt  <= INIT_CRED;
            credit_q  <= 1'b0;
            err_ovf_q <= 1'b0;
            err_dsp_q <= 1'b0;
        end else begin
            // Issue, dispatch and pop never target the same slot in one cycle.
            if (issue_acc) begin
                st_q[wr_idx] <= ST_ISSUED;
                wr_ptr       <= wr_ptr + PTR_ONE;
            end
            if (disp_ok) begin
                st_q[dp_idx] <= dispatch_kill ? ST_KILLED : ST_SENIOR;
                dp_ptr       <= dp_ptr + PTR_ONE;
            end
            if (pop) begin
                st_q[rd_idx] <= ST_EMPTY;
                rd_ptr       <= rd_ptr + PTR_ONE;
            end
            if (issue_valid && full) err_ovf_q <= 1'b1;
            if (disp_err)            err_dsp_q <= 1'b1;

            case (fsm_q)
                FSM_INIT: begin
                    credit_q <= 1'b1;
                    init_cnt <= init_cnt - PTR_ONE;
                    if (init_cnt == PTR_ONE) fsm_q <= FSM_RUN;
                end
                default: credit_q <= pop;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue_acc) begin
            inst_q[wr_idx] <= issue_inst;
            sb_q[wr_idx]   <= issue_sb_id;
            opnd_q[wr_idx] <= issue_scalar_opnd;
            vcsr_q[wr_idx] <= issue_vcsr;
        end
    end

endmodule

// File: doc/tt_vpu_ovi_issue_queue.md
Name: tt_vpu_ovi_issue_queue

Overview:
VPU-side buffer directly downstream of the tt_vpu_ovi Open Vector Interface wrapper. It captures OVI issue packets, tracks each one through the in-order dispatch protocol (next_senior / kill), and presents senior instructions in order to the vector execution front end. It owns the issue credit pool: it returns one issue_credit pulse for every entry freed, and grants DEPTH initial credits after reset.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, >= 2.
PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
issue_valid  input  1  OVI issue strobe
issue_inst  input  32  vector instruction
issue_sb_id  input  5  scoreboard id
issue_scalar_opnd  input  64  scalar operand
issue_vcsr  input  40  vector CSR snapshot
issue_credit  output  1  one-cycle credit return pulse to core
dispatch_sb_id  input  5  sb_id targeted by dispatch event
dispatch_next_senior  input  1  oldest undispatched entry becomes non-speculative
dispatch_kill  input  1  oldest undispatched entry is squashed
exe_valid  output  1  head entry is senior and offered
exe_ready  input  1  execution front end accepts head
exe_inst  output  32  head instruction
exe_sb_id  output  5  head sb_id
exe_scalar_opnd  output  64  head scalar operand
exe_vcsr  output  40  head vcsr
occupancy  output  PTR_W+1  entries in use, 0..DEPTH
err_overflow  output  1  sticky: issue received while full
err_dispatch  output  1  sticky: dispatch protocol violation

Behaviour:
- Clock clk; reset_n asynchronous active-low. In reset: all outputs 0, all pointers 0, all entry states EMPTY, FSM in INIT, init counter = DEPTH.
- Entry state per slot: EMPTY, ISSUED, SENIOR, KILLED. Three pointers with an extra wrap bit each: wr_ptr (alloc), dp_ptr (next entry to dispatch), rd_ptr (head). Invariant: rd <= dp <= wr.
- Credit FSM: INIT drives issue_credit=1 every cycle from the first clock after reset release, for exactly DEPTH cycles, then goes to RUN. In RUN, issue_credit is registered: high in cycle N+1 iff an entry was freed in cycle N. At most one free per cycle. Issues arriving during INIT are accepted normally.
- Issue: when issue_valid and not full, write fields to slot wr_ptr, state=ISSUED, wr_ptr++. When issue_valid and full, drop the packet, set err_overflow, leave state unchanged.
- Dispatch event (next_senior or kill), applied to slot dp_ptr:
  - next_senior sets the state to SENIOR; kill sets it to KILLED; dp_ptr++.
  - If next_senior and kill are asserted together, kill wins and err_dispatch is set.
  - If dispatch_sb_id differs from the slot sb_id, the event is still applied and err_dispatch is set.
  - If dp_ptr == wr_ptr (no undispatched entry), ignore the event and set err_dispatch.
  - An entry written in cycle N is not visible to a dispatch in cycle N; a dispatch in that case takes the dp==wr path.
- Head: exe_valid = (head state == SENIOR). exe_* are driven from the head slot registers (combinational read, no extra latency) and are 0 when exe_valid=0.
  - exe_valid && exe_ready pops the head in that cycle.
  - A KILLED head pops automatically in one cycle with exe_valid=0.
  - An ISSUED head stalls.
  - Each pop sets the slot to EMPTY, does rd_ptr++, and produces a credit pulse the next cycle.
- Latency:
  - Issue in cycle N, next_senior in N+1 -> exe_valid in N+2 (empty queue).
  - Pop in cycle M -> issue_credit in M+1.
  - Kill in N+1 -> free in N+2 -> credit in N+3.
- Simultaneous events: issue, dispatch and pop may all occur in one cycle.
  - occupancy = wr - rd, updated by +issue_accepted - pop.
  - A full queue that pops in a cycle still rejects an issue in that same cycle (full is evaluated on current state).
- Wrap-around: pointers wrap modulo DEPTH. full = (wr[PTR_W] != rd[PTR_W]) && (wr[PTR_W-1:0] == rd[PTR_W-1:0]).
- Error flags clear only on reset.

Test Plan:
- Reset release, DEPTH=4, no traffic -> issue_credit high cycles 1-4, low from cycle 5; occupancy=0; exe_valid=0.
- Issue sb_id=3, inst=0x02058057 in cycle 10; next_senior sb_id=3 in cycle 11 -> exe_valid=1 in cycle 12 with exe_sb_id=3, exe_inst=0x02058057; exe_ready=1 -> issue_credit=1 in cycle 13; occupancy 1->0.
- Issue sb_id 1,2; kill sb_id 1; next_senior sb_id 2 -> sb_id 1 never appears on exe_*; sb_id 2 is offered; two credit pulses total; err_dispatch=0.
- Fill 4 entries, all senior, exe_ready=0 for 5 cycles, then a 5th issue -> exe_valid held with stable head fields; err_overflow=1; occupancy stays 4; the 5th packet is never offered.
- next_senior with dispatch_sb_id=7 while the oldest undispatched entry is sb_id=5 -> err_dispatch=1; entry 5 still becomes senior and is offered.
- Ten back-to-back issue/senior/accept sequences with exe_ready=1 -> sb_ids offered in issue order across pointer wrap; occupancy <= 2; exactly 10 RUN-phase credit pulses.
